multicycle_ctrl_fsm: RTL

MULTICYCLE_CTRL_FSM -- requirements
Module: multicycle_ctrl_fsm

---
 rtl/multicycle_ctrl_fsm.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: control FSM for a multicycle RV32 subset core.
// in: clk, reset, op, zero, mem_ready  out: strobes, mux selects, imm_src, illegal, retired, state_o
module multicycle_ctrl_fsm #(
  parameter int MEM_WAIT   = 1,
  parameter int ENABLE_JAL = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_write,
  output logic             reg_write,
  output logic             adr_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic [1:0]       imm_src,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t state, nxt;
  logic   rdy, jal_ok, retire;
  logic   pcw, irw, mw, rw;

  assign rdy    = (MEM_WAIT == 0) ? 1'b1 : mem_ready;
  assign jal_ok = (ENABLE_JAL != 0);

  always_comb begin
    nxt = state;
    unique case (state)
      FETCH:    if (rdy) nxt = DECODE;
      DECODE: begin
        if (op == OP_LW || op == OP_SW) nxt = MEMADR;
        else if (op == OP_R)            nxt = EXECR;
        else if (op == OP_I)            nxt = EXECI;
        else if (op == OP_BEQ)          nxt = BEQ;
        else if (op == OP_JAL && jal_ok) nxt = JAL;
        else                            nxt = TRAP;
      end
      MEMADR:   nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (rdy) nxt = MEMWB;
      MEMWB:    nxt = FETCH;
      MEMWRITE: if (rdy) nxt = FETCH;
      EXECR:    nxt = ALUWB;
      EXECI:    nxt = ALUWB;
      ALUWB:    nxt = FETCH;
      BEQ:      nxt = FETCH;
      JAL:      nxt = ALUWB;
      TRAP:     nxt = TRAP;
      default:  nxt = FETCH;
    endcase
  end

  // JAL is excluded: it finishes through ALUWB and is counted there.
  assign retire = (nxt == FETCH) &&
                  (state == MEMWB || state == MEMWRITE ||
                   state == ALUWB || state == BEQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state <= nxt;
      if (nxt == TRAP) illegal <= 1'b1;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    pcw        = 1'b0;
    irw        = 1'b0;
    mw         = 1'b0;
    rw         = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 2'b00;
    unique case (state)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        irw        = rdy;
        pcw        = rdy;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        rw         = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mw      = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ALUWB:    rw = 1'b1;
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pcw       = zero;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pcw       = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated so nothing writes while reset is held.
  assign pc_write  = pcw & ~reset;
  assign ir_write  = irw & ~reset;
  assign mem_write = mw & ~reset;
  assign reg_write = rw & ~reset;

  always_comb begin
    imm_src = 2'b00;
    if (op == OP_SW)                 imm_src = 2'b01;
    else if (op == OP_BEQ)           imm_src = 2'b10;
    else if (op == OP_JAL && jal_ok) imm_src = 2'b11;
  end

  assign state_o = state;

endmodule
